// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller for a DDS phase accumulator: steps the
// registered tuning word M from a latched start word by a latched step, with per-word dwell.
module dds_sweep_ctrl #(
  parameter int WIDTH = 32,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [WIDTH-1:0] f_start,
  input  logic [WIDTH-1:0] f_step,
  input  logic [CW-1:0]    n_steps,
  input  logic [CW-1:0]    dwell,
  output logic [WIDTH-1:0] M,
  output logic [CW-1:0]    idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] m_nx;
  logic [CW-1:0]    idx_nx;
  logic             busy_nx, done_nx, load;

  // Shadow copies of the sweep program, frozen for the duration of a sweep.
  logic [WIDTH-1:0] f_start_r, f_step_r;
  logic [CW-1:0]    n_steps_r, dwell_r;
  logic             cont_r;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_nx = state;
    m_nx     = M;
    idx_nx   = idx;
    cnt_nx   = cnt;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          m_nx     = f_start;
          idx_nx   = '0;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
          state_nx = SWEEP;
        end
      end
      SWEEP: begin
        busy_nx = 1'b1;
        // Abort takes priority over everything, including the end of the sweep.
        if (stop) begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else if (cnt != dwell_r) begin
          cnt_nx = cnt + 1'b1;
        end else begin
          cnt_nx = '0;
          if (idx != n_steps_r) begin
            m_nx   = M + f_step_r;
            idx_nx = idx + 1'b1;
          end else if (cont_r) begin
            m_nx   = f_start_r;
            idx_nx = '0;
          end else begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      M     <= '0;
      idx   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      M     <= m_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  // NOTE: shadow registers are reset too, so a post-reset sweep never sees stale program values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_start_r <= '0;
      f_step_r  <= '0;
      n_steps_r <= '0;
      dwell_r   <= '0;
      cont_r    <= 1'b0;
    end else if (load) begin
      f_start_r <= f_start;
      f_step_r  <= f_step;
      n_steps_r <= n_steps;
      dwell_r   <= dwell;
      cont_r    <= cont;
    end
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Upstream control stage for the 32-bit accumulator/ROM function generator.
- Produces the registered phase-increment word M that drives the accumulator. M is stepped through a programmed linear frequency sweep: start word, step, step count and dwell time.
- Supports single-shot or continuous (wrapping) sweeps, with abort and completion signalling to the host controller.

Parameters:
- WIDTH, 32, bit width of tuning words and of M; equals the accumulator width.
- CW, 16, bit width of the step-count and dwell counters.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  sweep request; sampled in IDLE only.
- stop  input  1  abort request; sampled in SWEEP only.
- cont  input  1  1 = continuous sweep (wrap), 0 = single-shot; latched at start.
- f_start  input  WIDTH  first tuning word; latched at start.
- f_step  input  WIDTH  per-step increment, two's complement (negative gives a down-sweep); latched at start.
- n_steps  input  CW  number of increments per sweep; the sweep emits n_steps+1 distinct words.
- dwell  input  CW  each word is held for dwell+1 clock cycles.
- M  output  WIDTH  registered tuning word to the accumulator.
- idx  output  CW  index of the current step, 0..n_steps.
- busy  output  1  high while in SWEEP.
- done  output  1  one-cycle pulse at the end of a single-shot sweep.

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, M=0, idx=0, busy=0, done=0, dwell counter=0, shadow registers=0.
- States: IDLE, SWEEP, DONE.
- IDLE, start=1:
  - Latch f_start, f_step, n_steps, dwell and cont into shadow registers.
  - Next edge: M<=f_start, idx<=0, dwell counter<=0, busy<=1, state<=SWEEP.
  - Latency start->new M: 1 cycle.
  - stop is ignored in IDLE.
  - Input changes after the start cycle have no effect on the running sweep.
- IDLE, start=0: M, idx hold their last values.
- SWEEP, each cycle:
  - If dwell counter != dwell_r: dwell counter++.
  - Else, dwell counter<=0 and:
    - If idx != n_steps_r: M<=M+f_step_r (modulo 2^WIDTH, carry/overflow discarded), idx++.
    - Else, if cont_r=1: M<=f_start_r, idx<=0, remain in SWEEP.
    - Else, if cont_r=0: state<=DONE, busy<=0, M holds the final word.
- DONE:
  - done=1 for exactly one cycle; busy=0; state<=IDLE next edge.
  - A start in DONE is ignored.
- stop=1 in SWEEP: next edge state<=IDLE, busy<=0. M and idx freeze at their current values; no done pulse.
- start while busy (SWEEP or DONE): ignored. There is no restart without returning to IDLE.
- stop and sweep-end in the same cycle: stop wins (IDLE, no done).
- Boundary cases:
  - n_steps=0: a single word (f_start) is held for dwell+1 cycles, then DONE, or repeats indefinitely if cont.
  - dwell=0: M changes every cycle.
- Arithmetic: M wraps modulo 2^WIDTH. For example, M=0xFFFF_FFF0 plus f_step=0x20 gives 0x0000_0010.
- Outputs: all outputs come directly from flip-flops; no combinational path from inputs to outputs.
- Reset mid-sweep: immediate asynchronous return to the reset values above. The sweep does not resume after reset release.

Test Plan:
- Reset check: assert reset=0 mid-SWEEP. Required: M=0, idx=0, busy=0, done=0 asynchronously, before the next clk edge.
- Basic up-sweep, single-shot: f_start=0x0100_0000, f_step=0x0010_0000, n_steps=3, dwell=1, cont=0.
  - M sequence, each word for 2 cycles: 0x0100_0000, 0x0110_0000, 0x0120_0000, 0x0130_0000.
  - done pulses once, 1 cycle after the last word's dwell.
  - busy high for exactly 8 cycles.
- Down-sweep with wrap: f_start=0x0000_0010, f_step=0xFFFF_FFF0 (-16), n_steps=2, dwell=0.
  - M: 0x10, 0x0, 0xFFFF_FFF0, each for 1 cycle, then done.
- Continuous mode: n_steps=1, dwell=0, cont=1, f_start=5, f_step=3.
  - M alternates 5, 8, 5, 8 ...; idx alternates 0, 1; done never asserts.
  - stop then gives busy=0 next cycle, with M frozen.
- Abort vs end collision: assert stop in the final dwell cycle of a single-shot sweep.
  - Required: IDLE, no done pulse, M holds the final word.
- Ignored requests:
  - start pulsed during SWEEP with different inputs: no effect on M sequence.
  - n_steps=0, dwell=4: f_start held for 5 cycles, then done.
